// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the dual-port distributed RAM.
// Optional write-first read behaviour is selected with DPRAM_WRITE_FIRST_EN.
package dpram_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 6;
  localparam int DEFAULT_DATA_WIDTH   = 64;
  localparam int DEFAULT_BYTE_WIDTH   = 64;
  localparam int DEFAULT_READ_LATENCY = 0;
  localparam int MAX_READ_LATENCY     = 4;

  // Fixed widths let one merge function serve every instance configuration.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_LANES      = 256;

  function automatic int lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      strobe,
    input int                        byte_w
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (strobe[i / byte_w]) result[i] = new_word[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/dpram_read_pipe.sv
// Per-port read register chain: stage 0 gated by en, later stages by regce.
// LATENCY=0 degenerates to a combinational passthrough.
module dpram_read_pipe #(
  parameter int               LATENCY     = 0,
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             regce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, resetn, en, regce};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [LATENCY];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < LATENCY; k++) stage[k] <= RESET_VALUE;
        end else begin
          if (en) stage[0] <= din;
          if (regce) begin
            for (int k = 1; k < LATENCY; k++) stage[k] <= stage[k-1];
          end
        end
      end

      if (LATENCY == 1) begin : g_no_regce
        logic unused_regce;
        assign unused_regce = regce;
      end

      assign dout = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/dual_port_dist_ram.sv
// Simple dual-port LUT RAM: port A read/write with lane strobes, port B read-only.
// Define DPRAM_WRITE_FIRST_EN for write-first capture when READ_LATENCY >= 1.
module dual_port_dist_ram
  import dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int                    BYTE_WIDTH   = DEFAULT_BYTE_WIDTH,
  parameter int                    READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      en_a,
  input  logic [lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]  we_a,
  input  logic [ADDR_WIDTH-1:0]                     addr_a,
  input  logic [DATA_WIDTH-1:0]                     din_a,
  output logic [DATA_WIDTH-1:0]                     dout_a,
  input  logic                                      regce_a,
  input  logic                                      en_b,
  input  logic [ADDR_WIDTH-1:0]                     addr_b,
  output logic [DATA_WIDTH-1:0]                     dout_b,
  input  logic                                      regce_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || READ_LATENCY < 0 ||
        READ_LATENCY > MAX_READ_LATENCY || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_cfg
      $error("dual_port_dist_ram: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY");
    end
  endgenerate

`ifdef DPRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = (READ_LATENCY > 0);
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  // Zero at configuration time; reset deliberately leaves contents alone.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] merged_a;
  logic [DATA_WIDTH-1:0] word_a;
  logic [DATA_WIDTH-1:0] word_b;

  assign merged_a = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[addr_a]),
                                           MAX_DATA_WIDTH'(din_a),
                                           MAX_LANES'(we_a),
                                           BYTE_WIDTH));

  always_ff @(posedge clk) begin
    if (en_a) mem[addr_a] <= merged_a;
  end

  // With no strobes set the merged word equals the stored word, so en_a alone suffices.
  assign word_a = (WRITE_FIRST && en_a) ? merged_a : mem[addr_a];
  assign word_b = (WRITE_FIRST && en_a && (addr_b == addr_a)) ? merged_a : mem[addr_b];

  dpram_read_pipe #(
    .LATENCY     (READ_LATENCY),
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pipe_a (
    .clk    (clk),
    .resetn (resetn),
    .en     (en_a),
    .regce  (regce_a),
    .din    (word_a),
    .dout   (dout_a)
  );

  dpram_read_pipe #(
    .LATENCY     (READ_LATENCY),
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pipe_b (
    .clk    (clk),
    .resetn (resetn),
    .en     (en_b),
    .regce  (regce_b),
    .din    (word_b),
    .dout   (dout_b)
  );

endmodule

// File: tb/tb_dual_port_dist_ram.sv
// Bench for dual_port_dist_ram: three instances (latency 0/1/2), table vectors plus corner sequences.
// Expectations for read-during-write follow DPRAM_WRITE_FIRST_EN when it is defined.
module tb_dual_port_dist_ram;

  localparam logic [63:0] RV2 = 64'hDEAD_BEEF_0000_0001;

`ifdef DPRAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instance 0: defaults (latency 0, one 64-bit lane)
  logic        a0_en, a0_we, a0_regce, b0_en, b0_regce;
  logic [5:0]  a0_addr, b0_addr;
  logic [63:0] a0_din, a0_dout, b0_dout;
  // Instance 1: latency 1, byte lanes
  logic        a1_en, a1_regce, b1_en, b1_regce;
  logic [7:0]  a1_we;
  logic [5:0]  a1_addr, b1_addr;
  logic [63:0] a1_din, a1_dout, b1_dout;
  // Instance 2: latency 2, byte lanes, nonzero reset value
  logic        a2_en, a2_regce, b2_en, b2_regce;
  logic [7:0]  a2_we;
  logic [5:0]  a2_addr, b2_addr;
  logic [63:0] a2_din, a2_dout, b2_dout;

  dual_port_dist_ram dut0 (
    .clk(clk), .resetn(resetn),
    .en_a(a0_en), .we_a(a0_we), .addr_a(a0_addr), .din_a(a0_din), .dout_a(a0_dout), .regce_a(a0_regce),
    .en_b(b0_en), .addr_b(b0_addr), .dout_b(b0_dout), .regce_b(b0_regce)
  );

  dual_port_dist_ram #(.BYTE_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .en_a(a1_en), .we_a(a1_we), .addr_a(a1_addr), .din_a(a1_din), .dout_a(a1_dout), .regce_a(a1_regce),
    .en_b(b1_en), .addr_b(b1_addr), .dout_b(b1_dout), .regce_b(b1_regce)
  );

  dual_port_dist_ram #(.BYTE_WIDTH(8), .READ_LATENCY(2), .RESET_VALUE(RV2)) dut2 (
    .clk(clk), .resetn(resetn),
    .en_a(a2_en), .we_a(a2_we), .addr_a(a2_addr), .din_a(a2_din), .dout_a(a2_dout), .regce_a(a2_regce),
    .en_b(b2_en), .addr_b(b2_addr), .dout_b(b2_dout), .regce_b(b2_regce)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        we;
    logic [5:0]  addr_a;
    logic [63:0] din;
    logic [5:0]  addr_b;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] sb_q [$];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %-16s value %h", name, act);
    end else begin
      $display("FAIL %-16s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, 16'(i), 32'h1234_5678 ^ 32'(i * 7)};
  endfunction

  initial begin
    vecs[0] = '{"t0_wr5",      1'b1, 1'b1, 6'd5,  64'h1122_3344_5566_7788, 6'd5,
                64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788};
    vecs[1] = '{"t0_rd_other", 1'b0, 1'b0, 6'd5,  64'h0,                   6'd6,
                64'h1122_3344_5566_7788, 64'h0};
    vecs[2] = '{"t0_wr9",      1'b1, 1'b1, 6'd9,  64'h5,                   6'd9,
                64'h5, 64'h5};
    vecs[3] = '{"t0_en_off",   1'b0, 1'b1, 6'd9,  64'hFFFF_FFFF_FFFF_FFFF, 6'd9,
                64'h5, 64'h5};
    vecs[4] = '{"t0_wr0",      1'b1, 1'b1, 6'd0,  64'h0000_0000_0000_CAFE, 6'd63,
                64'h0000_0000_0000_CAFE, 64'h0};
    vecs[5] = '{"t0_wr63",     1'b1, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_CAFE};

    resetn = 1'b0;
    a0_en = 0; a0_we = 0; a0_addr = 0; a0_din = 0; a0_regce = 0; b0_en = 0; b0_addr = 0; b0_regce = 0;
    a1_en = 1; a1_we = 8'hFF; a1_addr = 6'd20; a1_din = 64'h2020_2020; a1_regce = 1;
    b1_en = 0; b1_addr = 0; b1_regce = 1;
    a2_en = 0; a2_we = 0; a2_addr = 0; a2_din = 0; a2_regce = 1; b2_en = 0; b2_addr = 0; b2_regce = 1;

    // Reset state; dut1 also writes addr 20 while reset is held.
    tick();
    tick();
    check("rst_a0",  a0_dout, 64'h0);
    check("rst_a1",  a1_dout, 64'h0);
    check("rst_b1",  b1_dout, 64'h0);
    check("rst_a2",  a2_dout, RV2);
    check("rst_b2",  b2_dout, RV2);
    a1_en = 0;
    #2 resetn = 1'b1;

    // Latency-0 table: write is visible right after the edge.
    for (int i = 0; i < 6; i++) begin
      a0_en = vecs[i].en; a0_we = vecs[i].we; a0_addr = vecs[i].addr_a;
      a0_din = vecs[i].din; b0_addr = vecs[i].addr_b;
      sb_q.push_back(vecs[i].exp_a);
      sb_q.push_back(vecs[i].exp_b);
      tick();
      check({vecs[i].name, "_a"}, a0_dout, sb_q.pop_front());
      check({vecs[i].name, "_b"}, b0_dout, sb_q.pop_front());
    end
    a0_en = 0;

    // Byte lanes on dut1.
    a1_en = 1; a1_we = 8'hFF; a1_addr = 6'd3; a1_din = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    a1_we = 8'h01; a1_din = 64'h0;
    tick();
    a1_we = 8'h00; b1_en = 1; b1_addr = 6'd3;
    tick();
    check("lane_a", a1_dout, 64'hFFFF_FFFF_FFFF_FF00);
    check("lane_b", b1_dout, 64'hFFFF_FFFF_FFFF_FF00);

    a1_en = 0; b1_addr = 6'd20;
    tick();
    check("wr_in_reset", b1_dout, 64'h2020_2020);
    b1_en = 0; b1_addr = 6'd3;
    tick();
    check("en_b_hold", b1_dout, 64'h2020_2020);

    // Read-during-write collision at addr 7.
    a1_en = 1; a1_we = 8'hFF; a1_addr = 6'd7; a1_din = 64'hA;
    tick();
    a1_din = 64'hB; b1_en = 1; b1_addr = 6'd7;
    tick();
    check("rdw_b", b1_dout, WF ? 64'hB : 64'hA);
    check("rdw_a", a1_dout, WF ? 64'hB : 64'hA);
    a1_en = 0;
    tick();
    check("rdw_b_next", b1_dout, 64'hB);

    // Asynchronous reset pulse mid-cycle.
    b1_addr = 6'd3;
    tick();
    check("pre_pulse_b", b1_dout, 64'hFFFF_FFFF_FFFF_FF00);
    #2 resetn = 1'b0;
    #1;
    check("pulse_b1", b1_dout, 64'h0);
    check("pulse_a1", a1_dout, 64'h0);
    check("pulse_b2", b2_dout, RV2);
    tick();
    check("pulse_hold_b1", b1_dout, 64'h0);
    #2 resetn = 1'b1;
    tick();
    check("recover_b1", b1_dout, 64'hFFFF_FFFF_FFFF_FF00);

    // Fill dut2.
    a2_en = 1; a2_we = 8'hFF;
    a2_addr = 6'd1; a2_din = 64'h111;
    tick();
    a2_addr = 6'd2; a2_din = 64'h222;
    tick();
    for (int i = 0; i < 8; i++) begin
      a2_addr = 6'(30 + i); a2_din = pat(i);
      tick();
    end
    a2_en = 0;

    // regce_b stall on the output stage.
    b2_en = 1; b2_regce = 1; b2_addr = 6'd1;
    tick();
    tick();
    check("regce_fill", b2_dout, 64'h111);
    b2_regce = 0; b2_addr = 6'd2;
    tick();
    check("regce_hold1", b2_dout, 64'h111);
    tick();
    check("regce_hold2", b2_dout, 64'h111);
    b2_regce = 1;
    tick();
    check("regce_release", b2_dout, 64'h222);

    // Streaming reads through the two-stage pipe via the scoreboard.
    for (int i = 0; i < 8; i++) begin
      b2_addr = 6'(30 + i);
      sb_q.push_back(pat(i));
      tick();
      if (i >= 1) check($sformatf("stream_%0d", i - 1), b2_dout, sb_q.pop_front());
    end
    b2_en = 0;
    tick();
    check("stream_7", b2_dout, sb_q.pop_front());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
